// File: rtl/bus_memio_slave_if.sv
// Multiplexed address/strobe bus shared by memory and I/O slaves.
// Master drives address, space, latch enable and strobes; slave answers READY/err.
interface bus_memio_slave_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] Address;
  logic              IOM;
  logic              ALE;
  logic              CS;
  logic              RD;
  logic              WR;
  logic              READY;
  logic              err;

  modport master (
    output Address, IOM, ALE, CS, RD, WR,
    input  READY, err
  );

  modport slave (
    input  Address, IOM, ALE, CS, RD, WR,
    output READY, err
  );
endinterface

// File: rtl/bus_memio_slave.sv
// Memory or I/O mapped RAM slave with programmable wait states.
// Define MEMIO_BOUNDS_ERR_EN to flag in-space out-of-range accesses on err.
module bus_memio_slave #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH       = 256,
  parameter bit                IS_IO       = 1'b0,
  parameter int                WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire  [DATA_W-1:0]  data,
  bus_memio_slave_if.slave   bus
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic       IOM_WANT = !IS_IO;
  localparam logic [3:0] WS       = WAIT_STATES[3:0];

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ACCESS,
    HOLD
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_iom;
  logic              lat_cs;
  logic              op_wr;
  logic [3:0]        cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              space_ok;
  logic              in_range;
  logic              hit;
  logic              rd_only;
  logic              wr_only;
  logic              strobe_held;

  logic              ready;
  logic              data_oe;
  logic              do_write;
  logic              load_cnt;

  assign offset   = lat_addr - BASE_ADDR;
  assign idx      = offset[IDX_W-1:0];
  assign space_ok = !lat_cs && (lat_iom == IOM_WANT);
  assign in_range = (lat_addr >= BASE_ADDR) &&
                    ({1'b0, offset} < (ADDR_W+1)'(DEPTH));
  assign hit      = space_ok && in_range;

  assign rd_only  = !bus.RD &&  bus.WR;
  assign wr_only  =  bus.RD && !bus.WR;

  // The strobe that started the access must stay low through WAIT
  assign strobe_held = op_wr ? !bus.WR : !bus.RD;

  always_comb begin
    state_n  = state;
    ready    = 1'b1;
    data_oe  = 1'b0;
    do_write = 1'b0;
    load_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = IDLE;
      end
      ADDR: begin
        if (hit && (rd_only || wr_only)) begin
          load_cnt = 1'b1;
          state_n  = (WS == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        ready = 1'b0;
        if (!strobe_held)
          state_n = IDLE;
        else if (cnt <= 4'd1)
          state_n = ACCESS;
      end
      ACCESS: begin
        state_n  = HOLD;
        data_oe  = !op_wr;
        do_write = op_wr;
      end
      HOLD: begin
        data_oe = !op_wr && !bus.RD;
        if (bus.RD && bus.WR)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // A new address phase wins over anything in flight
    if (bus.ALE) begin
      state_n  = ADDR;
      do_write = 1'b0;
      load_cnt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_iom  <= 1'b0;
      lat_cs   <= 1'b1;
      op_wr    <= 1'b0;
    end else begin
      state <= state_n;
      if (bus.ALE) begin
        lat_addr <= bus.Address;
        lat_iom  <= bus.IOM;
        lat_cs   <= bus.CS;
      end
      if (load_cnt) begin
        cnt   <= WS;
        op_wr <= !bus.WR;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (do_write)
      mem[idx] <= data;
  end

  assign data      = data_oe ? mem[idx] : 'z;
  assign bus.READY = ready;

`ifdef MEMIO_BOUNDS_ERR_EN
  logic first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      first <= 1'b0;
    else
      first <= bus.ALE;
  end

  assign bus.err = (state == ADDR) && first && space_ok && !in_range;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: doc/bus_memio_slave.md
BUS_MEMIO_SLAVE -- requirements
Module: bus_memio_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bus and storage word width.
REQ-002 SHALL have parameter ADDR_W, default 20, address bus width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first decoded address.
REQ-004 SHALL have parameter DEPTH, default 256, number of words; decoded range is BASE_ADDR..BASE_ADDR+DEPTH-1.
REQ-005 SHALL have parameter IS_IO, default 0, selecting the responding space: 0 = memory (IOM=1), 1 = I/O (IOM=0).
REQ-006 SHALL have parameter WAIT_STATES, default 1, range 0..15, READY-low cycles inserted per access.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 data  inout  DATA_W  bidirectional bus; driven only during read data phase, else high-Z.
REQ-010 Address  input  ADDR_W  address, sampled while ALE=1.
REQ-011 IOM  input  1  memory/IO indicator, sampled with Address.
REQ-012 ALE  input  1  address latch enable, active-high.
REQ-013 CS  input  1  chip select, active-low, sampled with Address.
REQ-014 RD  input  1  read strobe, active-low.
REQ-015 WR  input  1  write strobe, active-low.
REQ-016 READY  output  1  1 = access may complete; 0 = wait state.
REQ-017 err  output  1  one-cycle out-of-range pulse (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, ADDR, WAIT, ACCESS, HOLD.
REQ-019 Any state, rising edge with ALE=1: latch Address, IOM, CS into registers and go to ADDR; a pending access in WAIT/ACCESS is aborted with no memory write.
REQ-020 hit SHALL be: latched CS=0, latched IOM matching IS_IO, latched address within decoded range; index = address - BASE_ADDR, width clog2(DEPTH).
REQ-021 ADDR, hit=0: remain in ADDR until next ALE; data high-Z, READY=1, no access.
REQ-022 ADDR, hit=1, exactly one of RD/WR low: load wait counter with WAIT_STATES; go to WAIT, or directly to ACCESS if WAIT_STATES=0.
REQ-023 ADDR, RD and WR both low: no access, data high-Z; remain in ADDR.
REQ-024 WAIT: READY=0; counter decrements each cycle; go to ACCESS on the edge where counter reaches 0.
REQ-025 ACCESS lasts exactly one cycle, READY=1; write: memory[index] captures data on the edge leaving ACCESS; read: data driven with memory[index].
REQ-026 HOLD: READY=1; read data driven while RD=0; return to IDLE when RD=1 and WR=1.
REQ-027 Strobe released during WAIT: return to IDLE, no write, data high-Z.
REQ-028 Exactly one memory write per write cycle; repeated WR low in HOLD SHALL NOT rewrite.
REQ-029 READY SHALL be 1 in every state except WAIT.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, READY=1, err=0, data high-Z, wait counter 0, latched address 0.
REQ-031 Memory contents SHALL NOT be cleared by reset; a write in progress at reset is discarded.

Configuration
REQ-032 Macro MEMIO_BOUNDS_ERR_EN defined: latched CS=0 and IOM matching IS_IO but address outside range -> err=1 for exactly the first cycle in ADDR; no access.
REQ-033 MEMIO_BOUNDS_ERR_EN undefined: err tied 0; out-of-range cycles silently ignored.

Verification
REQ-034 Defaults; ALE with Address=20'h00010, IOM=1, CS=0; WR=0, data=8'hA5 -> READY=0 for 1 cycle, then memory[16]=8'hA5; data never driven by block.
REQ-035 Read back 20'h00010, RD=0 -> READY low 1 cycle, then data=8'hA5 until RD=1, then high-Z.
REQ-036 WAIT_STATES=0, IS_IO=1, BASE_ADDR=20'h0FF00, DEPTH=16; write 8'h3C to 20'h0FF0F with IOM=0 -> no READY low; read returns 8'h3C; same access with IOM=1 -> no response.
REQ-037 MEMIO_BOUNDS_ERR_EN defined, defaults, Address=20'h00100, CS=0, IOM=1 -> err=1 one cycle, READY=1, data high-Z; undefined -> err=0.
REQ-038 WAIT_STATES=3, write 8'h11 to index 5, assert rst during 2nd WAIT cycle -> READY=1 and state IDLE immediately; memory[5] unchanged.
REQ-039 RD=0 and WR=0 together on a hit -> data high-Z, READY=1, no memory change.
